// File: rtl/day2_dff_variants.sv
// Three parallel register lanes on one data input: no reset, synchronous clear, and
// synchronous storage with an output forced while reset is low. Optional lane-compare flag under DAY2_LANE_MISMATCH_EN.
module day2_dff_variants #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_norst_o,
    output logic [WIDTH-1:0] q_syncrst_o,
`ifdef DAY2_LANE_MISMATCH_EN
    output logic [WIDTH-1:0] q_asyncrst_o,
    output logic             lane_mismatch_o
`else
    output logic [WIDTH-1:0] q_asyncrst_o
`endif
);

    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_a;

    always_ff @(posedge clk) begin
        r_n <= d_i;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s <= RESET_VALUE;
            r_a <= RESET_VALUE;
        end else begin
            r_s <= d_i;
            r_a <= d_i;
        end
    end

    // Forcing the output from the live reset level makes the clear visible mid-cycle.
    assign q_norst_o    = r_n;
    assign q_syncrst_o  = r_s;
    assign q_asyncrst_o = (!reset) ? RESET_VALUE : r_a;

`ifdef DAY2_LANE_MISMATCH_EN
    // Lanes differ only at an edge that samples reset low while the sync lane still
    // holds pre-reset data, so the comparison is not masked by reset.
    always_ff @(posedge clk) begin
        lane_mismatch_o <= (q_syncrst_o != q_asyncrst_o);
    end
`endif

endmodule

// File: tb/tb_day2_dff_variants.sv
// Scoreboard bench for day2_dff_variants: a 1-bit default instance and an
// 8-bit instance with RESET_VALUE 8'hA5, both on one clock and one reset.
module tb_day2_dff_variants;

    logic       clk = 1'b0;
    logic       reset;
    logic       d1;
    logic [7:0] d8;
    logic       qn1, qs1, qa1;
    logic [7:0] qn8, qs8, qa8;

    localparam logic [7:0] RV8 = 8'hA5;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic       n1, s1, a1;
        logic [7:0] n8, s8, a8;
    } exp_t;

    exp_t sb[$];
    logic       m_s1;
    logic [7:0] m_s8;

    always #5 clk = ~clk;

    day2_dff_variants u_w1 (
        .clk(clk), .reset(reset), .d_i(d1),
        .q_norst_o(qn1), .q_syncrst_o(qs1), .q_asyncrst_o(qa1)
    );

    day2_dff_variants #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_w8 (
        .clk(clk), .reset(reset), .d_i(d8),
        .q_norst_o(qn8), .q_syncrst_o(qs8), .q_asyncrst_o(qa8)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, push the expected post-edge values, then
    // compare just after the edge while reset is still at its sampled level.
    task automatic cyc(input logic dv1, input logic [7:0] dv8, input logic rv);
        exp_t e;
        d1 = dv1;
        d8 = dv8;
        reset = rv;
        m_s1 = rv ? dv1 : 1'b0;
        m_s8 = rv ? dv8 : RV8;
        e.n1 = dv1;
        e.s1 = m_s1;
        e.a1 = rv ? m_s1 : 1'b0;
        e.n8 = dv8;
        e.s8 = m_s8;
        e.a8 = rv ? m_s8 : RV8;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("norst1", {31'b0, qn1}, {31'b0, e.n1});
        chk("sync1",  {31'b0, qs1}, {31'b0, e.s1});
        chk("async1", {31'b0, qa1}, {31'b0, e.a1});
        chk("norst8", {24'b0, qn8}, {24'b0, e.n8});
        chk("sync8",  {24'b0, qs8}, {24'b0, e.s8});
        chk("async8", {24'b0, qa8}, {24'b0, e.a8});
    endtask

    initial begin
        reset = 1'b0;
        d1 = 1'b0;
        d8 = 8'h00;
        m_s1 = 1'b0;
        m_s8 = RV8;

        // Reset state and priority of reset over d_i.
        cyc(1'b1, 8'hFF, 1'b0);
        cyc(1'b1, 8'hFF, 1'b0);

        // Load ones, then a sub-cycle reset glitch between edges.
        cyc(1'b1, 8'h5A, 1'b1);
        cyc(1'b1, 8'h5A, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("glitch_async1", {31'b0, qa1}, 32'd0);
        chk("glitch_async8", {24'b0, qa8}, {24'b0, RV8});
        chk("glitch_sync1",  {31'b0, qs1}, 32'd1);
        chk("glitch_norst1", {31'b0, qn1}, 32'd1);
        chk("glitch_sync8",  {24'b0, qs8}, 32'h5A);
        #2 reset = 1'b1;
        #1;
        chk("glitch_rel_async1", {31'b0, qa1}, 32'd1);
        chk("glitch_rel_async8", {24'b0, qa8}, 32'h5A);
        chk("glitch_rel_sync1",  {31'b0, qs1}, 32'd1);

        // Reset held across one edge, then release.
        cyc(1'b1, 8'h77, 1'b0);
        #3;
        chk("held_async1", {31'b0, qa1}, 32'd0);
        cyc(1'b1, 8'h77, 1'b1);

        // Random data with reset released.
        for (int i = 0; i < 10; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1);

        // Long reset with toggling data.
        for (int i = 0; i < 5; i++)
            cyc(1'(i % 2), 8'(8'h10 + i), 1'b0);

        // Wide lane: reset to A5, then 3C after release.
        cyc(1'b0, 8'h3C, 1'b0);
        cyc(1'b1, 8'h3C, 1'b1);
        cyc(1'b0, 8'hC3, 1'b1);

        if (sb.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
